// File: rtl/reg_access_ctrl.sv
// reg_access_ctrl
//   Host-side access controller for a DW-bit select/write register. Host
//   commands are buffered in a DEPTH-entry FIFO. Each command becomes a
//   one-cycle sel/wr access on the register port. Read data is returned
//   over a valid/ready response channel.
//
// Ports
//   clk, rstn                  clock, async active-low reset
//   cmd_valid/cmd_ready        host command handshake (cmd_ready = !full)
//   cmd_wr, cmd_wdata          command type (1 = write) and write data
//   rsp_valid/rsp_ready        read response handshake
//   rsp_rdata                  read response data
//   reg_sel, reg_wr, reg_wdata registered register-port controls
//   reg_rdata                  combinational register read data
//   busy                       FIFO non-empty or FSM not idle
//   wr_cnt, rd_cnt             wrapping completed-write / read-response counters
module reg_access_ctrl #(
    parameter int DW    = 16,
    parameter int DEPTH = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic             cmd_wr,
    input  logic [DW-1:0]    cmd_wdata,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [DW-1:0]    rsp_rdata,
    output logic             reg_sel,
    output logic             reg_wr,
    output logic [DW-1:0]    reg_wdata,
    input  logic [DW-1:0]    reg_rdata,
    output logic             busy,
    output logic [CNT_W-1:0] wr_cnt,
    output logic [CNT_W-1:0] rd_cnt
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef struct packed {
        logic          wr;
        logic [DW-1:0] wdata;
    } cmd_t;

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    // ---------------- command FIFO ----------------
    cmd_t          mem [DEPTH];
    logic [AW-1:0] wptr, rptr;
    logic [CW-1:0] count;
    logic          full, empty, push, pop;
    cmd_t          head;

    assign full      = (count == CW'(DEPTH));
    assign empty     = (count == '0);
    assign cmd_ready = !full;
    // Full blocks the push even when a pop happens in the same cycle.
    assign push      = cmd_valid && !full;
    assign head      = mem[rptr];

    always_ff @(posedge clk) begin
        if (push) mem[wptr] <= '{wr: cmd_wr, wdata: cmd_wdata};
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push) wptr <= wptr + 1'b1;
            if (pop)  rptr <= rptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // ---------------- access FSM ----------------
    state_t        state, state_n;
    logic          sel_n, wr_n, rspv_n, wr_inc, rd_inc;
    logic [DW-1:0] wdata_n, rspd_n;

    always_comb begin
        state_n = state;
        pop     = 1'b0;
        sel_n   = reg_sel;
        wr_n    = reg_wr;
        wdata_n = reg_wdata;
        rspv_n  = rsp_valid;
        rspd_n  = rsp_rdata;
        wr_inc  = 1'b0;
        rd_inc  = 1'b0;
        case (state)
            IDLE: begin
                if (!empty) begin
                    pop     = 1'b1;
                    sel_n   = 1'b1;
                    wr_n    = head.wr;
                    wdata_n = head.wr ? head.wdata : '0;
                    state_n = ACCESS;
                end
            end
            ACCESS: begin
                if (reg_wr) begin
                    wr_inc = 1'b1;
                    // Chain the next queued command directly so that
                    // back-to-back writes sustain one access per cycle.
                    if (!empty) begin
                        pop     = 1'b1;
                        sel_n   = 1'b1;
                        wr_n    = head.wr;
                        wdata_n = head.wr ? head.wdata : '0;
                    end else begin
                        sel_n   = 1'b0;
                        wr_n    = 1'b0;
                        wdata_n = '0;
                        state_n = IDLE;
                    end
                end else begin
                    // reg_rdata is valid only while sel=1/wr=0, i.e. now.
                    rspd_n  = reg_rdata;
                    rspv_n  = 1'b1;
                    sel_n   = 1'b0;
                    wr_n    = 1'b0;
                    wdata_n = '0;
                    state_n = RESP;
                end
            end
            RESP: begin
                // No new access until the response is taken, so it can
                // never be overwritten.
                if (rsp_ready) begin
                    rspv_n  = 1'b0;
                    rd_inc  = 1'b1;
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= IDLE;
            reg_sel   <= 1'b0;
            reg_wr    <= 1'b0;
            reg_wdata <= '0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            wr_cnt    <= '0;
            rd_cnt    <= '0;
        end else begin
            state     <= state_n;
            reg_sel   <= sel_n;
            reg_wr    <= wr_n;
            reg_wdata <= wdata_n;
            rsp_valid <= rspv_n;
            rsp_rdata <= rspd_n;
            if (wr_inc) wr_cnt <= wr_cnt + 1'b1;
            if (rd_inc) rd_cnt <= rd_cnt + 1'b1;
        end
    end

    assign busy = !empty || (state != IDLE);

endmodule

// File: tb/tb_reg_access_ctrl.sv
module tb_reg_access_ctrl;

    logic        clk = 1'b0;
    logic        rstn;
    logic        cmd_valid, cmd_wr, rsp_ready;
    logic [15:0] cmd_wdata;
    logic        cmd_ready, rsp_valid, reg_sel, reg_wr, busy;
    logic [15:0] rsp_rdata, reg_wdata, reg_rdata;
    logic [7:0]  wr_cnt, rd_cnt;

    // Second instance with 2-bit counters, fed the same stimulus.
    logic        w_cmd_ready, w_rsp_valid, w_reg_sel, w_reg_wr, w_busy;
    logic [15:0] w_rsp_rdata, w_reg_wdata;
    logic [1:0]  w_wr_cnt, w_rd_cnt;

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    // Register model: written on a sel/wr cycle, read data valid on sel/!wr.
    logic [15:0] regq = 16'h0000;
    always @(posedge clk) if (reg_sel && reg_wr) regq <= reg_wdata;
    assign reg_rdata = (reg_sel && !reg_wr) ? regq : 16'hDEAD;

    reg_access_ctrl #(.DW(16), .DEPTH(4), .CNT_W(8)) dut (
        .clk(clk), .rstn(rstn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_wr(cmd_wr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .reg_sel(reg_sel), .reg_wr(reg_wr), .reg_wdata(reg_wdata), .reg_rdata(reg_rdata),
        .busy(busy), .wr_cnt(wr_cnt), .rd_cnt(rd_cnt));

    reg_access_ctrl #(.DW(16), .DEPTH(4), .CNT_W(2)) u_wrap (
        .clk(clk), .rstn(rstn),
        .cmd_valid(cmd_valid), .cmd_ready(w_cmd_ready), .cmd_wr(cmd_wr), .cmd_wdata(cmd_wdata),
        .rsp_valid(w_rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(w_rsp_rdata),
        .reg_sel(w_reg_sel), .reg_wr(w_reg_wr), .reg_wdata(w_reg_wdata), .reg_rdata(reg_rdata),
        .busy(w_busy), .wr_cnt(w_wr_cnt), .rd_cnt(w_rd_cnt));

    // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        cmd_valid = 0; cmd_wr = 0; cmd_wdata = 0; rsp_ready = 1;
        rstn = 0;
        repeat (3) tick();
        rstn = 1;
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        n_chk++; if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL reset_cmd_ready: got %0h exp 1", cmd_ready); end
        n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %0h exp 0", busy); end
        n_chk++; if (reg_sel !== 1'b0) begin n_fail++; $display("FAIL reset_sel: got %0h exp 0", reg_sel); end
        n_chk++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_valid: got %0h exp 0", rsp_valid); end
        n_chk++; if (wr_cnt !== 8'd0) begin n_fail++; $display("FAIL reset_wr_cnt: got %0d exp 0", wr_cnt); end
        n_chk++; if (rd_cnt !== 8'd0) begin n_fail++; $display("FAIL reset_rd_cnt: got %0d exp 0", rd_cnt); end
        tick();
        n_chk++; if (reg_sel !== 1'b0) begin n_fail++; $display("FAIL reset_idle_sel: got %0h exp 0", reg_sel); end
    endtask

    task automatic test_write_read();
        do_reset();
        cmd_valid = 1; cmd_wr = 1; cmd_wdata = 16'hA5A5;
        tick();                                   // edge N: write pushed
        n_chk++; if (reg_sel !== 1'b0) begin n_fail++; $display("FAIL wr_rd_lat: sel got %0h exp 0", reg_sel); end
        cmd_wr = 0; cmd_wdata = 16'hFFFF;
        tick();                                   // N+1: write issued, read pushed
        n_chk++; if ({reg_sel, reg_wr, reg_wdata} !== {2'b11, 16'hA5A5}) begin n_fail++;
            $display("FAIL wr_rd_wcycle: sel/wr/wdata got %0h/%0h/%0h exp 1/1/a5a5", reg_sel, reg_wr, reg_wdata); end
        cmd_valid = 0;
        tick();                                   // N+2: write done, read issued
        n_chk++; if ({reg_sel, reg_wr, reg_wdata} !== {2'b10, 16'h0000}) begin n_fail++;
            $display("FAIL wr_rd_rcycle: sel/wr/wdata got %0h/%0h/%0h exp 1/0/0", reg_sel, reg_wr, reg_wdata); end
        n_chk++; if (wr_cnt !== 8'd1) begin n_fail++; $display("FAIL wr_rd_wr_cnt: got %0d exp 1", wr_cnt); end
        tick();                                   // N+3: response captured
        n_chk++; if ({rsp_valid, rsp_rdata} !== {1'b1, 16'hA5A5}) begin n_fail++;
            $display("FAIL wr_rd_rsp: valid/data got %0h/%0h exp 1/a5a5", rsp_valid, rsp_rdata); end
        n_chk++; if (reg_sel !== 1'b0) begin n_fail++; $display("FAIL wr_rd_sel_drop: got %0h exp 0", reg_sel); end
        tick();                                   // N+4: handshake
        n_chk++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL wr_rd_rsp_drop: got %0h exp 0", rsp_valid); end
        n_chk++; if (rd_cnt !== 8'd1) begin n_fail++; $display("FAIL wr_rd_rd_cnt: got %0d exp 1", rd_cnt); end
        n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL wr_rd_busy: got %0h exp 0", busy); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        cmd_valid = 1; cmd_wr = 1; cmd_wdata = 16'h0001;
        tick();
        n_chk++; if (reg_sel !== 1'b0) begin n_fail++; $display("FAIL b2b_first: sel got %0h exp 0", reg_sel); end
        for (int k = 1; k <= 3; k++) begin
            cmd_wdata = 16'(k + 1);
            tick();
            n_chk++; if ({reg_sel, reg_wr, reg_wdata} !== {2'b11, 16'(k)}) begin n_fail++;
                $display("FAIL b2b_cycle%0d: sel/wr/wdata got %0h/%0h/%0h exp 1/1/%0h", k, reg_sel, reg_wr, reg_wdata, k); end
        end
        cmd_valid = 0;
        tick();
        n_chk++; if ({reg_sel, reg_wr, reg_wdata} !== {2'b11, 16'h0004}) begin n_fail++;
            $display("FAIL b2b_cycle4: sel/wr/wdata got %0h/%0h/%0h exp 1/1/4", reg_sel, reg_wr, reg_wdata); end
        tick();
        n_chk++; if ({reg_sel, reg_wr, reg_wdata} !== 18'h0) begin n_fail++;
            $display("FAIL b2b_end: sel/wr/wdata got %0h/%0h/%0h exp 0/0/0", reg_sel, reg_wr, reg_wdata); end
        n_chk++; if (wr_cnt !== 8'd4) begin n_fail++; $display("FAIL b2b_wr_cnt: got %0d exp 4", wr_cnt); end
        n_chk++; if (regq !== 16'h0004) begin n_fail++; $display("FAIL b2b_reg: got %0h exp 4", regq); end
    endtask

    task automatic test_full_backpressure();
        do_reset();
        rsp_ready = 0;
        cmd_valid = 1; cmd_wr = 1; cmd_wdata = 16'h1234;
        tick();                                   // N: write pushed
        cmd_wr = 0;
        tick();                                   // N+1: read pushed
        cmd_valid = 0;
        tick();                                   // N+2: read issued
        tick();                                   // N+3: RESP
        n_chk++; if ({rsp_valid, rsp_rdata} !== {1'b1, 16'h1234}) begin n_fail++;
            $display("FAIL bp_rsp: valid/data got %0h/%0h exp 1/1234", rsp_valid, rsp_rdata); end
        for (int k = 1; k <= 4; k++) begin
            n_chk++; if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL bp_ready%0d: got %0h exp 1", k, cmd_ready); end
            cmd_valid = 1; cmd_wr = 1; cmd_wdata = 16'(k * 16'h11);
            tick();
        end
        n_chk++; if (cmd_ready !== 1'b0) begin n_fail++; $display("FAIL bp_full: cmd_ready got %0h exp 0", cmd_ready); end
        cmd_wdata = 16'h0055;                     // 5th command must be refused
        tick();
        tick();
        cmd_valid = 0;
        n_chk++; if (cmd_ready !== 1'b0) begin n_fail++; $display("FAIL bp_still_full: cmd_ready got %0h exp 0", cmd_ready); end
        n_chk++; if ({rsp_valid, rsp_rdata, reg_sel} !== {1'b1, 16'h1234, 1'b0}) begin n_fail++;
            $display("FAIL bp_hold: valid/data/sel got %0h/%0h/%0h exp 1/1234/0", rsp_valid, rsp_rdata, reg_sel); end
        rsp_ready = 1;
        tick();                                   // handshake
        n_chk++; if (rsp_valid !== 1'b0 || rd_cnt !== 8'd1) begin n_fail++;
            $display("FAIL bp_release: valid/rd_cnt got %0h/%0d exp 0/1", rsp_valid, rd_cnt); end
        for (int k = 1; k <= 4; k++) begin
            tick();
            n_chk++; if ({reg_sel, reg_wr, reg_wdata} !== {2'b11, 16'(k * 16'h11)}) begin n_fail++;
                $display("FAIL bp_drain%0d: sel/wr/wdata got %0h/%0h/%0h exp 1/1/%0h", k, reg_sel, reg_wr, reg_wdata, k * 16'h11); end
        end
        tick();
        n_chk++; if (reg_sel !== 1'b0 || busy !== 1'b0) begin n_fail++;
            $display("FAIL bp_done: sel/busy got %0h/%0h exp 0/0", reg_sel, busy); end
        n_chk++; if (wr_cnt !== 8'd5) begin n_fail++; $display("FAIL bp_wr_cnt: got %0d exp 5", wr_cnt); end
        n_chk++; if (regq !== 16'h0044) begin n_fail++; $display("FAIL bp_reg: got %0h exp 44", regq); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        rsp_ready = 0;
        cmd_valid = 1; cmd_wr = 1; cmd_wdata = 16'hBEEF;
        tick();                                   // N
        cmd_wr = 0;
        tick();                                   // N+1
        cmd_wr = 1; cmd_wdata = 16'h0777;
        tick();                                   // N+2
        cmd_wdata = 16'h0888;
        tick();                                   // N+3: RESP, 2 queued
        cmd_valid = 0;
        n_chk++; if ({rsp_valid, rsp_rdata, busy} !== {1'b1, 16'hBEEF, 1'b1}) begin n_fail++;
            $display("FAIL mid_pre: valid/data/busy got %0h/%0h/%0h exp 1/beef/1", rsp_valid, rsp_rdata, busy); end
        #2 rstn = 0;                              // between edges: asynchronous
        #1;
        n_chk++; if ({reg_sel, reg_wr, reg_wdata, rsp_valid, rsp_rdata} !== 35'h0) begin n_fail++;
            $display("FAIL mid_async: sel/wr/wdata/valid/data got %0h/%0h/%0h/%0h/%0h exp all 0", reg_sel, reg_wr, reg_wdata, rsp_valid, rsp_rdata); end
        n_chk++; if ({wr_cnt, rd_cnt} !== 16'h0 || cmd_ready !== 1'b1 || busy !== 1'b0) begin n_fail++;
            $display("FAIL mid_async_misc: wr_cnt/rd_cnt/ready/busy got %0d/%0d/%0h/%0h exp 0/0/1/0", wr_cnt, rd_cnt, cmd_ready, busy); end
        tick();
        rstn = 1;
        for (int k = 0; k < 3; k++) begin
            tick();
            n_chk++; if (reg_sel !== 1'b0 || busy !== 1'b0) begin n_fail++;
                $display("FAIL mid_after%0d: sel/busy got %0h/%0h exp 0/0", k, reg_sel, busy); end
        end
    endtask

    task automatic test_counter_wrap();
        do_reset();
        for (int i = 0; i < 7; i++) begin
            cmd_valid = (i < 5); cmd_wr = 1; cmd_wdata = 16'(i + 1);
            tick();                               // edge N+i
            if (i >= 2) begin
                n_chk++; if (w_wr_cnt !== 2'((i - 1) % 4)) begin n_fail++;
                    $display("FAIL wrap_cnt%0d: got %0d exp %0d", i - 1, w_wr_cnt, (i - 1) % 4); end
            end
        end
        cmd_valid = 0;
        n_chk++; if (wr_cnt !== 8'd5) begin n_fail++; $display("FAIL wrap_wide_cnt: got %0d exp 5", wr_cnt); end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_back_to_back();
        test_full_backpressure();
        test_reset_mid();
        test_counter_wrap();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
